// File: rtl/obs_scheduler.sv
// Obstacle scheduler: spawns, scrolls and retires obstacle slots, and maps the beam onto the shared sprite ROM.
// Optional feature macro: OBS_COLLIDE_EN enables the sticky dino/obstacle collision flag.
module obs_scheduler #(
  parameter int NUM_SLOTS   = 2,
  parameter int X_W         = 10,
  parameter int SCREEN_W    = 640,
  parameter int GROUND_Y    = 400,
  parameter int SCALE_SHIFT = 3,
  parameter int MIN_GAP     = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_frame_tick,
  input  logic                 i_game_run,
  input  logic                 i_clear,
  input  logic [3:0]           i_speed,
  input  logic [X_W-1:0]       i_hpos,
  input  logic [X_W-1:0]       i_vpos,
  input  logic                 i_sprite_color,
  input  logic                 i_dino_px,
  output logic [2:0]           o_rom_counter,
  output logic                 o_obs_px,
  output logic [NUM_SLOTS-1:0] o_active,
  output logic                 o_collide
);

  localparam logic [X_W:0]   SPR_W   = (X_W+1)'(2 << SCALE_SHIFT);
  localparam logic [X_W-1:0] TOP_Y   = X_W'(GROUND_Y - (4 << SCALE_SHIFT));
  localparam logic [X_W-1:0] BOT_Y   = X_W'(GROUND_Y);
  localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_W);
  localparam logic [7:0]     GAP     = 8'(MIN_GAP);

  logic [X_W-1:0]       x_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] active;
  logic [7:0]           cooldown;
  logic [7:0]           lfsr;
  logic                 lfsr_fb;
  logic [X_W-1:0]       speed_ext;
  logic                 frame_upd;
  logic [NUM_SLOTS-1:0] spawn_sel;
  logic                 any_free;

  assign o_active  = active;
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign speed_ext = {{(X_W-4){1'b0}}, i_speed};
  assign frame_upd = i_frame_tick & i_game_run;

  // Free-slot search uses pre-tick state, so a slot retiring this tick is not reused yet
  always_comb begin
    spawn_sel = '0;
    any_free  = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!active[s] && !any_free) begin
        spawn_sel[s] = 1'b1;
        any_free     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= '0;
      cooldown <= GAP;
      for (int s = 0; s < NUM_SLOTS; s++) x_q[s] <= '0;
    end else if (i_clear) begin
      active   <= '0;
      cooldown <= GAP;
    end else if (frame_upd) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (active[s]) begin
          if (x_q[s] < speed_ext) active[s] <= 1'b0;
          else                    x_q[s]    <= x_q[s] - speed_ext;
        end else if (cooldown == 8'd0 && spawn_sel[s]) begin
          active[s] <= 1'b1;
          x_q[s]    <= SPAWN_X;
        end
      end
      if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
      else if (any_free)    cooldown <= GAP + {3'b000, lfsr[4:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               lfsr <= 8'hA5;
    else if (i_frame_tick) lfsr <= {lfsr[6:0], lfsr_fb};
  end

  // Stage p0: bounding-box test against every slot, lowest index wins
  logic [X_W:0]   hx;
  logic [X_W:0]   xs;
  logic [X_W-1:0] dx;
  logic [X_W-1:0] dy;
  logic           v_in;
  logic           hit_p0;
  logic [2:0]     rom_p0;
  logic           render_unused;

  always_comb begin
    hit_p0 = 1'b0;
    rom_p0 = 3'd0;
    dx     = '0;
    xs     = '0;
    hx     = {1'b0, i_hpos};
    v_in   = (i_vpos >= TOP_Y) && (i_vpos < BOT_Y);
    dy     = i_vpos - TOP_Y;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      xs = {1'b0, x_q[s]};
      if (!hit_p0 && active[s] && v_in && (hx >= xs) && (hx < xs + SPR_W)) begin
        hit_p0 = 1'b1;
        dx     = i_hpos - x_q[s];
        rom_p0 = {dy[SCALE_SHIFT+1:SCALE_SHIFT], dx[SCALE_SHIFT]};
      end
    end
  end

  assign render_unused = ^{dx, dy};

  // Stage p1: registered ROM address and pixel flag
  logic [2:0] rom_p1;
  logic       px_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_p1 <= 3'd0;
      px_p1  <= 1'b0;
    end else begin
      rom_p1 <= rom_p0;
      px_p1  <= hit_p0;
    end
  end

  assign o_rom_counter = rom_p1;
  assign o_obs_px      = px_p1;

`ifdef OBS_COLLIDE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     o_collide <= 1'b0;
    else if (px_p1 & i_sprite_color & i_dino_px) o_collide <= 1'b1;
    else if (i_clear)                            o_collide <= 1'b0;
  end
`else
  logic collide_unused;
  assign collide_unused = i_sprite_color ^ i_dino_px;
  assign o_collide      = 1'b0;
`endif

endmodule

// File: tb/tb_obs_scheduler.sv
// Self-checking bench for obs_scheduler: directed scenarios plus randomized play against a frame-level model.
module tb_obs_scheduler;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_frame_tick = 1'b0;
  logic          i_game_run = 1'b0;
  logic          i_clear = 1'b0;
  logic [3:0]    i_speed = 4'd0;
  logic [9:0]    i_hpos = 10'd0;
  logic [9:0]    i_vpos = 10'd0;
  logic          i_sprite_color = 1'b0;
  logic          i_dino_px = 1'b0;
  logic [2:0]    o_rom_counter;
  logic          o_obs_px;
  logic [NS-1:0] o_active;
  logic          o_collide;

  obs_scheduler #(.NUM_SLOTS(NS)) dut (
    .clk(clk), .rst(rst), .i_frame_tick(i_frame_tick), .i_game_run(i_game_run),
    .i_clear(i_clear), .i_speed(i_speed), .i_hpos(i_hpos), .i_vpos(i_vpos),
    .i_sprite_color(i_sprite_color), .i_dino_px(i_dino_px),
    .o_rom_counter(o_rom_counter), .o_obs_px(o_obs_px), .o_active(o_active),
    .o_collide(o_collide)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Frame-level model of the obstacle world
  bit m_act[NS];
  int m_x[NS];
  int m_cd, m_lfsr;
  bit m_px, m_col;
  int m_rom;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] act_vec();
    logic [15:0] v = '0;
    for (int s = 0; s < NS; s++) v[s] = m_act[s];
    return v;
  endfunction

  function automatic bit all_busy();
    for (int s = 0; s < NS; s++) if (!m_act[s]) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin m_act[s] = 0; m_x[s] = 0; end
    m_cd = 48; m_lfsr = 'hA5; m_px = 0; m_col = 0; m_rom = 0;
  endtask

  task automatic render_model(input int h, input int v, output bit px, output int rom);
    px = 0; rom = 0;
    for (int s = 0; s < NS; s++) begin
      if (!px && m_act[s] && h >= m_x[s] && h < m_x[s] + 16 && v >= 368 && v < 400) begin
        px  = 1;
        rom = ((((v - 368) / 8) % 4) * 2) + (((h - m_x[s]) / 8) % 2);
      end
    end
  endtask

  task automatic frame_model(input bit tk, input bit run, input bit clr, input int spd);
    int f = -1;
    if (clr) begin
      for (int s = 0; s < NS; s++) m_act[s] = 0;
      m_cd = 48;
    end else if (tk && run) begin
      for (int s = NS - 1; s >= 0; s--) if (!m_act[s]) f = s;
      for (int s = 0; s < NS; s++) begin
        if (m_act[s]) begin
          if (m_x[s] < spd) m_act[s] = 0;
          else              m_x[s] = m_x[s] - spd;
        end
      end
      if (m_cd > 0) m_cd--;
      else if (f >= 0) begin
        m_act[f] = 1; m_x[f] = 640;
        m_cd = 48 + (m_lfsr % 32);
      end
    end
    if (tk) m_lfsr = ((m_lfsr * 2) % 256) |
                     (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
  endtask

  // One clock: predict, drive, clock, compare every output
  task automatic cyc(input bit tk, input bit run, input bit clr, input int spd,
                     input int h, input int v, input bit col, input bit dino);
    bit ep; int er;
    render_model(h, v, ep, er);
`ifdef OBS_COLLIDE_EN
    if (m_px && col && dino) m_col = 1;
    else if (clr)            m_col = 0;
`else
    m_col = 0;
`endif
    m_px = ep; m_rom = er;
    frame_model(tk, run, clr, spd);
    i_frame_tick = tk; i_game_run = run; i_clear = clr; i_speed = 4'(spd);
    i_hpos = 10'(h); i_vpos = 10'(v); i_sprite_color = col; i_dino_px = dino;
    @(posedge clk); #1;
    chk("active", 16'(o_active), act_vec());
    chk("obs_px", 16'(o_obs_px), 16'(m_px));
    chk("rom_counter", 16'(o_rom_counter), 16'(m_rom));
    chk("collide", 16'(o_collide), 16'(m_col));
  endtask

  task automatic frame(input bit run, input int spd);
    cyc(1, run, 0, spd, 0, 0, 0, 0);
    cyc(0, run, 0, spd, 0, 0, 0, 0);
  endtask

  initial begin
    int h, v, s, hx;
    bit tk, clr, run;
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_active", 16'(o_active), 16'd0);
    chk("reset_rom", 16'(o_rom_counter), 16'd0);
    chk("reset_px", 16'(o_obs_px), 16'd0);
    chk("reset_collide", 16'(o_collide), 16'd0);

    // 48 cooldown frames, then the 49th spawns slot 0
    for (int i = 0; i < 48; i++) frame(1, 4);
    chk("no_spawn_48", 16'(o_active), 16'd0);
    frame(1, 4);
    chk("spawn_49", 16'(o_active), 16'd1);
    for (int i = 0; i < 10; i++) frame(1, 4);

    cyc(0, 1, 0, 4, 608, 384, 0, 0);
    chk("hit_px", 16'(o_obs_px), 16'd1);
    chk("hit_rom", 16'(o_rom_counter), 16'b101);
    cyc(0, 1, 0, 4, 599, 384, 0, 0);
    chk("left_edge_px", 16'(o_obs_px), 16'd0);
    cyc(0, 1, 0, 4, 615, 399, 0, 0);
    chk("corner_rom", 16'(o_rom_counter), 16'b111);
    cyc(0, 1, 0, 4, 616, 384, 0, 0);
    cyc(0, 1, 0, 4, 600, 367, 0, 0);
    cyc(0, 1, 0, 4, 600, 368, 0, 0);
    chk("top_row_rom", 16'(o_rom_counter), 16'b000);

    // Paused frames hold the world
    for (int i = 0; i < 5; i++) frame(0, 9);

    // Fill both slots, hold full with cooldown stuck at 0, then retire
    for (int i = 0; i < 200; i++) frame(1, 1);
    chk("both_full", 16'(o_active), 16'b11);
    for (int i = 0; i < 40; i++) frame(1, 1);
    s = 0;
    while (all_busy() && s < 100) begin frame(1, 15); s++; end
    chk("retire_seen", 16'(all_busy()), 16'd0);
    frame(1, 15);
    chk("deferred_spawn", 16'(o_active), 16'b11);

    // Collision on a live obstacle, then clear
    hx = m_act[0] ? m_x[0] : m_x[1];
    cyc(0, 1, 0, 4, hx, 390, 1, 1);
    cyc(0, 1, 0, 4, hx, 390, 1, 1);
    cyc(0, 1, 0, 4, 0, 0, 0, 0);
    cyc(0, 1, 0, 4, 0, 0, 0, 0);
`ifdef OBS_COLLIDE_EN
    chk("collide_sticky", 16'(o_collide), 16'd1);
`endif
    cyc(0, 1, 1, 4, 0, 0, 0, 0);
    chk("clear_active", 16'(o_active), 16'd0);
    chk("clear_collide", 16'(o_collide), 16'd0);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      clr = ($urandom_range(0, 299) == 0);
      tk  = !clr && ($urandom_range(0, 2) == 0);
      run = ($urandom_range(0, 7) != 0);
      s   = $urandom_range(0, NS - 1);
      h   = m_act[s] ? m_x[s] + $urandom_range(0, 24) - 4 : $urandom_range(0, 1023);
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      v   = $urandom_range(360, 405);
      cyc(tk, run, clr, $urandom_range(0, 15), h, v, 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-frame
    for (int i = 0; i < 60; i++) frame(1, 3);
    rst = 1'b1;
    #2;
    chk("async_rst_active", 16'(o_active), 16'd0);
    chk("async_rst_px", 16'(o_obs_px), 16'd0);
    chk("async_rst_collide", 16'(o_collide), 16'd0);
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 48; i++) frame(1, 5);
    chk("rst_no_spawn", 16'(o_active), 16'd0);
    frame(1, 5);
    chk("rst_spawn", 16'(o_active), 16'd1);
    for (int i = 0; i < 300; i++) frame(1, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
